// File: rtl/scu_uts_reader.sv
// scu_uts_reader: APB3 register front-end for the SCU UTS stamp counter.
// Requests 64-bit snapshots from the counter, captures them and returns
// them as two 32-bit words (SNAP_LO / SNAP_HI).
// Optional build macro: SCU_UTS_READER_TIMEOUT_EN bounds the WAIT state to
// TIMEOUT_CYC cycles and reports a timeout through pslverr_o / STATUS bit2.
module scu_uts_reader #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic              uts_counter_clr_o,
  output logic              uts_counter_value_read_o,
  input  logic              uts_counter_load_pulse_i,
  input  logic [63:0]       uts_counter_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_LO     = 2'd2;
  localparam logic [1:0] OFS_HI     = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_d;
  logic [31:0] snap_lo;
  logic [31:0] snap_hi;
  logic        snap_valid;
  logic        clr_q;
  logic        read_q;
  logic        sticky;
  logic        err_q;
  logic        timeout_hit;

  logic [1:0]  ofs;
  logic        setup;
  logic        access;
  logic        lo_setup;
  logic        lo_access;
  logic        lo_pending;
  logic        ctrl_wr;
  logic        snap_wr;
  logic        capture;
  logic        busy;
  logic [31:0] rdata;
  logic        unused_bits;

  // Bus decode; only paddr_i[3:2] selects a register.
  assign ofs        = paddr_i[3:2];
  assign setup      = psel_i & ~penable_i;
  assign access     = psel_i & penable_i;
  assign lo_setup   = setup & ~pwrite_i & (ofs == OFS_LO);
  assign lo_access  = access & ~pwrite_i & (ofs == OFS_LO);
  // A SNAP_LO read in either phase is waiting for a snapshot word.
  assign lo_pending = psel_i & ~pwrite_i & (ofs == OFS_LO);
  assign ctrl_wr    = access & pwrite_i & (ofs == OFS_CTRL);
  assign snap_wr    = ctrl_wr & pwdata_i[1];
  assign capture    = (state == ST_WAIT) & uts_counter_load_pulse_i;
  assign busy       = (state != ST_IDLE);

  assign unused_bits = ^{paddr_i, pwdata_i, 32'(TIMEOUT_CYC)};

`ifdef SCU_UTS_READER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = (state == ST_WAIT) & ~uts_counter_load_pulse_i &
                       (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Counts cycles spent in WAIT; cleared everywhere else.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Timeout flags: err_q marks the following RESP as an error response.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q  <= 1'b0;
      sticky <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (timeout_hit) begin
        sticky <= 1'b1;
      end else if (ctrl_wr && pwdata_i[2]) begin
        sticky <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_q       = 1'b0;
  assign sticky      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (lo_setup || snap_wr) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (capture || timeout_hit) begin
          state_d = lo_pending ? ST_RESP : ST_IDLE;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered counter controls: request pulse follows REQ, clear follows CTRL.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      read_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      read_q <= (state_d == ST_REQ);
      if (ctrl_wr) begin
        clr_q <= pwdata_i[0];
      end
    end
  end

  // Snapshot capture on the counter's load pulse while waiting for it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      snap_lo    <= 32'h0;
      snap_hi    <= 32'h0;
      snap_valid <= 1'b0;
    end else if (capture) begin
      snap_lo    <= uts_counter_i[31:0];
      snap_hi    <= uts_counter_i[63:32];
      snap_valid <= 1'b1;
    end
  end

  // Read data mux; zero whenever the access is not completing.
  always_comb begin
    rdata = 32'h0;
    if (state == ST_RESP) begin
      rdata = err_q ? 32'h0 : snap_lo;
    end else if (access && !pwrite_i && !lo_access) begin
      case (ofs)
        OFS_CTRL:   rdata = {31'h0, clr_q};
        OFS_STATUS: rdata = {29'h0, sticky, busy, snap_valid};
        OFS_HI:     rdata = snap_hi;
        default:    rdata = 32'h0;
      endcase
    end
  end

  assign prdata_o                 = rdata;
  assign pready_o                 = (state == ST_RESP) | (access & ~lo_access);
  assign pslverr_o                = (state == ST_RESP) & err_q;
  assign uts_counter_clr_o        = clr_q;
  assign uts_counter_value_read_o = read_q;

endmodule

// File: tb/tb_scu_uts_reader.sv
// Self-checking bench for scu_uts_reader: register table, hand sequences
// for snapshot corner cases, and a randomized run against a register model.
module tb_scu_uts_reader;

  localparam int unsigned AW = 12;
`ifdef SCU_UTS_READER_TIMEOUT_EN
  localparam int STALL = 10;
`else
  localparam int STALL = 30;
`endif

  logic          clk_i;
  logic          rst_n_i;
  logic          psel_i;
  logic          penable_i;
  logic          pwrite_i;
  logic [AW-1:0] paddr_i;
  logic [31:0]   pwdata_i;
  logic [31:0]   prdata_o;
  logic          pready_o;
  logic          pslverr_o;
  logic          clr_o;
  logic          read_o;
  logic          load_i;
  logic [63:0]   cnt_i;

  scu_uts_reader #(.ADDR_W(AW), .TIMEOUT_CYC(16)) dut (
    .clk_i                    (clk_i),
    .rst_n_i                  (rst_n_i),
    .psel_i                   (psel_i),
    .penable_i                (penable_i),
    .pwrite_i                 (pwrite_i),
    .paddr_i                  (paddr_i),
    .pwdata_i                 (pwdata_i),
    .prdata_o                 (prdata_o),
    .pready_o                 (pready_o),
    .pslverr_o                (pslverr_o),
    .uts_counter_clr_o        (clr_o),
    .uts_counter_value_read_o (read_o),
    .uts_counter_load_pulse_i (load_i),
    .uts_counter_i            (cnt_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // counter model controls
  logic [63:0] cnt_val  = 64'h0;
  logic        resp_on  = 1'b1;
  int          resp_lat = 1;
  int          spur_req = 0;
  int          spur_done = 0;
  int          read_cnt = 0;

  // register model
  logic [31:0] m_lo, m_hi;
  logic        m_valid, m_clr, m_sticky;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // count request-pulse cycles
  initial begin
    forever begin
      @(negedge clk_i);
      if (read_o === 1'b1) read_cnt++;
    end
  end

  // UTS counter model: answers a request after resp_lat cycles with the
  // current value (zero while clear is held); garbage on the bus otherwise.
  initial begin
    load_i = 1'b0;
    cnt_i  = 64'h0;
    forever begin
      @(negedge clk_i);
      if (read_o === 1'b1 && resp_on) begin
        repeat (resp_lat) @(posedge clk_i);
        #1;
        load_i = 1'b1;
        cnt_i  = (clr_o === 1'b1) ? 64'h0 : cnt_val;
        @(posedge clk_i);
        #1;
        load_i = 1'b0;
        cnt_i  = {$urandom, $urandom};
      end else if (spur_done != spur_req) begin
        @(posedge clk_i);
        #1;
        load_i = 1'b1;
        cnt_i  = {$urandom, $urandom};
        @(posedge clk_i);
        #1;
        load_i = 1'b0;
        spur_done++;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [1:0] ofs, input logic [31:0] wd, input int limit,
                     output logic [31:0] rd, output int waits, output logic err, output logic done);
    logic [7:0] hi_bits;
    hi_bits = 8'($urandom);
    @(posedge clk_i);
    #1;
    psel_i    = 1'b1;
    penable_i = 1'b0;
    pwrite_i  = wr;
    paddr_i   = {hi_bits, ofs, 2'b00};
    pwdata_i  = wd;
    @(posedge clk_i);
    #1;
    penable_i = 1'b1;
    waits = 0;
    done  = 1'b0;
    rd    = 32'h0;
    err   = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk_i);
      if (pready_o === 1'b1) begin
        done = 1'b1;
        rd   = prdata_o;
        err  = pslverr_o;
      end else begin
        waits++;
      end
    end
    @(posedge clk_i);
    #1;
    psel_i    = 1'b0;
    penable_i = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [1:0] ofs, input logic [31:0] exp, input int exp_waits);
    logic [31:0] rd;
    int waits;
    logic err, done;
    apb(1'b0, ofs, 32'h0, 60, rd, waits, err, done);
    check({name, "_done"}, 64'(done), 64'h1);
    check({name, "_rdata"}, 64'(rd), 64'(exp));
    check({name, "_slverr"}, 64'(err), 64'h0);
    if (exp_waits >= 0) check({name, "_waits"}, 64'(waits), 64'(exp_waits));
  endtask

  task automatic do_write(input string name, input logic [1:0] ofs, input logic [31:0] wd);
    logic [31:0] rd;
    int waits;
    logic err, done;
    apb(1'b1, ofs, wd, 10, rd, waits, err, done);
    check({name, "_done"}, 64'(done), 64'h1);
    check({name, "_waits"}, 64'(waits), 64'h0);
    check({name, "_slverr"}, 64'(err), 64'h0);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  ofs;
    logic [31:0] wd;
    logic [31:0] exp;
    int          waits;
    int          pulses;
    logic        clr;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] rd;
    int          waits, base, op, sel;
    logic        err, done, stalled;
    logic [31:0] w;
    logic [63:0] cap;

    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = '0; pwdata_i = 32'h0;
    rst_n_i = 1'b0;

    vecs[0]  = '{1'b0, 2'd1, 32'h0,         32'h0,   0, 0, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,         32'h0,   0, 0, 1'b0};
    vecs[2]  = '{1'b0, 2'd3, 32'h0,         32'h0,   0, 0, 1'b0};
    vecs[3]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0,   0, 0, 1'b0};
    vecs[4]  = '{1'b0, 2'd1, 32'h0,         32'h0,   0, 0, 1'b0};
    vecs[5]  = '{1'b0, 2'd2, 32'h0,         32'hF0,  2, 1, 1'b0};
    vecs[6]  = '{1'b0, 2'd3, 32'h0,         32'h1,   0, 0, 1'b0};
    vecs[7]  = '{1'b0, 2'd1, 32'h0,         32'h1,   0, 0, 1'b0};
    vecs[8]  = '{1'b1, 2'd0, 32'hFFFF_FFFD, 32'h0,   0, 0, 1'b1};
    vecs[9]  = '{1'b0, 2'd0, 32'h0,         32'h1,   0, 0, 1'b1};
    vecs[10] = '{1'b0, 2'd2, 32'h0,         32'h0,   2, 1, 1'b1};
    vecs[11] = '{1'b0, 2'd3, 32'h0,         32'h0,   0, 0, 1'b1};
    vecs[12] = '{1'b1, 2'd0, 32'h0,         32'h0,   0, 0, 1'b0};
    vecs[13] = '{1'b0, 2'd0, 32'h0,         32'h0,   0, 0, 1'b0};

    // reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_outputs", 64'({prdata_o, pready_o, pslverr_o, clr_o, read_o}), 64'h0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_outputs", 64'({prdata_o, pready_o, pslverr_o, clr_o, read_o}), 64'h0);

    // register table with counter at 0x1_0000_00F0
    cnt_val  = 64'h0000_0001_0000_00F0;
    resp_lat = 1;
    for (int i = 0; i < 14; i++) begin
      base = read_cnt;
      apb(vecs[i].wr, vecs[i].ofs, vecs[i].wd, 40, rd, waits, err, done);
      check($sformatf("vec%0d_done", i), 64'(done), 64'h1);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp));
      check($sformatf("vec%0d_waits", i), 64'(waits), 64'(vecs[i].waits));
      check($sformatf("vec%0d_slverr", i), 64'(err), 64'h0);
      check($sformatf("vec%0d_pulses", i), 64'(read_cnt - base), 64'(vecs[i].pulses));
      check($sformatf("vec%0d_clr", i), 64'(clr_o), 64'(vecs[i].clr));
    end
    m_lo = 32'h0; m_hi = 32'h0; m_valid = 1'b1; m_clr = 1'b0; m_sticky = 1'b0;

    // CTRL-triggered snapshot: busy visible, second SNAP ignored
    resp_lat = 8;
    cnt_val  = 64'hDEAD_BEEF_1234_5678;
    base = read_cnt;
    do_write("busy_snap", 2'd0, 32'h2);
    do_read("busy_status", 2'd1, 32'h3, 0);
    do_write("busy_snap2", 2'd0, 32'h2);
    repeat (12) @(posedge clk_i);
    #1;
    check("busy_pulses", 64'(read_cnt - base), 64'h1);
    do_read("busy_status_done", 2'd1, 32'h1, 0);
    do_read("busy_hi", 2'd3, 32'hDEAD_BEEF, 0);
    m_hi = 32'hDEAD_BEEF; m_lo = 32'h1234_5678;

    // SNAP_LO read joins an in-flight CTRL snapshot
    cnt_val = 64'hCAFE_0001_8765_4321;
    base = read_cnt;
    do_write("join_snap", 2'd0, 32'h2);
    do_read("join_lo", 2'd2, 32'h8765_4321, -1);
    check("join_pulses", 64'(read_cnt - base), 64'h1);
    do_read("join_hi", 2'd3, 32'hCAFE_0001, 0);
    m_hi = 32'hCAFE_0001; m_lo = 32'h8765_4321;
    resp_lat = 1;

    // load pulse outside WAIT is ignored
    cnt_val = 64'h5555_5555_5555_5555;
    spur_req++;
    repeat (4) @(posedge clk_i);
    do_read("spur_hi", 2'd3, m_hi, 0);
    do_read("spur_status", 2'd1, 32'h1, 0);

`ifdef SCU_UTS_READER_TIMEOUT_EN
    // counter never answers: error response after the WAIT budget
    resp_on = 1'b0;
    base = read_cnt;
    apb(1'b0, 2'd2, 32'h0, 60, rd, waits, err, done);
    check("to_done", 64'(done), 64'h1);
    check("to_rdata", 64'(rd), 64'h0);
    check("to_slverr", 64'(err), 64'h1);
    check("to_waits", 64'(waits), 64'd17);
    check("to_pulses", 64'(read_cnt - base), 64'h1);
    resp_on = 1'b1;
    do_read("to_status", 2'd1, 32'h5, 0);
    do_read("to_hi_kept", 2'd3, m_hi, 0);
    do_write("to_w1c", 2'd0, 32'h4);
    do_read("to_status_clr", 2'd1, 32'h1, 0);
`endif

    // stalled SNAP_LO read, then reset while waiting
    do_write("pre_rst_clr", 2'd0, 32'h1);
    check("pre_rst_clr_o", 64'(clr_o), 64'h1);
    resp_on = 1'b0;
    base = read_cnt;
    @(posedge clk_i);
    #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 12'h008;
    @(posedge clk_i);
    #1;
    penable_i = 1'b1;
    stalled = 1'b1;
    repeat (STALL) begin
      @(negedge clk_i);
      if (pready_o !== 1'b0) stalled = 1'b0;
    end
    check("stall_no_ready", 64'(stalled), 64'h1);
    check("stall_pulses", 64'(read_cnt - base), 64'h1);
    #2;
    rst_n_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
    #1;
    check("midrst_outputs", 64'({prdata_o, pready_o, pslverr_o, clr_o, read_o}), 64'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    resp_on = 1'b1;
    do_read("after_rst_status", 2'd1, 32'h0, 0);
    cnt_val = 64'h0000_0007_0000_0ABC;
    do_read("after_rst_lo", 2'd2, 32'h0000_0ABC, 2);
    do_read("after_rst_hi", 2'd3, 32'h0000_0007, 0);
    m_lo = 32'h0000_0ABC; m_hi = 32'h7; m_valid = 1'b1; m_clr = 1'b0; m_sticky = 1'b0;

    // randomized operations against the register model
    for (int it = 0; it < 60; it++) begin
      resp_lat = int'($urandom_range(1, 3));
      op = int'($urandom_range(0, 5));
      case (op)
        0: cnt_val = {$urandom, $urandom};
        1: begin
          cap  = m_clr ? 64'h0 : cnt_val;
          base = read_cnt;
          do_read($sformatf("rnd%0d_lo", it), 2'd2, cap[31:0], 1 + resp_lat);
          check($sformatf("rnd%0d_lo_pulses", it), 64'(read_cnt - base), 64'h1);
          m_lo = cap[31:0]; m_hi = cap[63:32]; m_valid = 1'b1;
        end
        2: do_read($sformatf("rnd%0d_hi", it), 2'd3, m_hi, 0);
        3: do_read($sformatf("rnd%0d_status", it), 2'd1, {29'h0, m_sticky, 1'b0, m_valid}, 0);
        4: begin
          w = $urandom;
          sel = int'($urandom_range(0, 1));
          w[1] = sel[0];
          base = read_cnt;
          do_write($sformatf("rnd%0d_ctrl", it), 2'd0, w);
          m_clr = w[0];
          if (w[2]) m_sticky = 1'b0;
          if (w[1]) begin
            repeat (resp_lat + 4) @(posedge clk_i);
            cap = m_clr ? 64'h0 : cnt_val;
            m_lo = cap[31:0]; m_hi = cap[63:32]; m_valid = 1'b1;
          end
          check($sformatf("rnd%0d_ctrl_pulses", it), 64'(read_cnt - base), 64'(w[1]));
          check($sformatf("rnd%0d_clr_o", it), 64'(clr_o), 64'(m_clr));
        end
        default: do_read($sformatf("rnd%0d_ctrl_rd", it), 2'd0, {31'h0, m_clr}, 0);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
